if_fetch_unit: RTL and testbench

Instruction-fetch front end: owns the program counter and acts as the requesting side of the instruction-memory read port (addr / enable / nop-inject out, instruction / nop-return in). Issues one word-aligned fetch per unstalled cycle and tracks the 1-cycle memory read latency. Squashes wrong-path fetches on redirect and hands {instruction, PC, valid} to decode. Sits between the instruction memory and the decode stage.

---
 rtl/if_pkg.sv | 18 +
 rtl/if_perf_cnt.sv | 21 ++
 rtl/if_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } if_state_e;

  // A PC is unfetchable when misaligned or past the last memory word.
  function automatic logic pc_fault(input logic [31:0] pc, input int unsigned words);
    return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= words);
  endfunction

endpackage

// File: rtl/if_perf_cnt.sv
// Fetch and bubble event counters for the fetch front end (wrap mod 2^32).
module if_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        bubble_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (fetch_inc)  fetch_cnt  <= fetch_cnt + 32'd1;
      if (bubble_inc) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC ownership, 1-cycle imem request/response, redirect squash.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 513
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  output logic        imem_nop,
  input  logic [31:0] imem_instr,
  input  logic        imem_nop_ret,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        if_fault,
  output logic [31:0] if_fault_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_issued_q, pc_issued_d;
  logic        issued_q, issued_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  logic [31:0] fetch_addr;
  logic        fetch_en;
  logic        fetch_nop;
  logic        halted;
  logic        resp_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      pc_issued_q <= RESET_PC;
      issued_q    <= 1'b0;
      fault_pc_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_issued_q <= pc_issued_d;
      issued_q    <= issued_d;
      fault_pc_q  <= fault_pc_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_issued_d = pc_issued_q;
    issued_d    = issued_q;
    fault_pc_d  = fault_pc_q;
    fetch_addr  = pc_q;
    fetch_en    = 1'b0;
    fetch_nop   = 1'b0;
    halted      = 1'b0;

    unique case (state_q)
      BOOT: begin
        // Stall and redirect are ignored here: the first fetch always goes out.
        fetch_addr = RESET_PC;
        if (pc_fault(RESET_PC, IMEM_WORDS)) begin
          fault_pc_d = RESET_PC;
          issued_d   = 1'b0;
          state_d    = HALT;
        end else begin
          fetch_en    = 1'b1;
          pc_d        = RESET_PC + PC_STEP;
          pc_issued_d = RESET_PC;
          issued_d    = 1'b1;
          state_d     = RUN;
        end
      end

      RUN: begin
        if (redirect_valid) begin
          issued_d = 1'b0;
          if (pc_fault(redirect_pc, IMEM_WORDS)) begin
            fault_pc_d = redirect_pc;
            state_d    = HALT;
          end else begin
            // The strobe with nop set makes memory return a NOP for the wrong path.
            fetch_en  = 1'b1;
            fetch_nop = 1'b1;
            pc_d      = redirect_pc;
          end
        end else if (!stall) begin
          if (pc_fault(pc_q, IMEM_WORDS)) begin
            fault_pc_d = pc_q;
            issued_d   = 1'b0;
            state_d    = HALT;
          end else begin
            fetch_en    = 1'b1;
            pc_d        = pc_q + PC_STEP;
            pc_issued_d = pc_q;
            issued_d    = 1'b1;
          end
        end
      end

      HALT: begin
        halted = 1'b1;
        if (redirect_valid && !pc_fault(redirect_pc, IMEM_WORDS)) begin
          halted   = 1'b0;
          pc_d     = redirect_pc;
          issued_d = 1'b0;
          state_d  = RUN;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  // Outputs are forced to their reset values for as long as rst is held.
  assign resp_valid  = issued_q & ~imem_nop_ret;
  assign imem_en     = ~rst & fetch_en;
  assign imem_nop    = ~rst & fetch_nop;
  assign imem_addr   = rst ? RESET_PC : fetch_addr;
  assign if_instr    = imem_instr;
  assign if_pc       = rst ? RESET_PC : pc_issued_q;
  assign if_valid    = ~rst & resp_valid & ~redirect_valid & (state_q != HALT);
  assign if_fault    = ~rst & halted;
  assign if_fault_pc = rst ? '0 : fault_pc_q;

`ifdef IF_PERF_CNT_EN
  // The BOOT cycle counts as the initial bubble: nothing is presented yet.
  if_perf_cnt u_perf_cnt (
    .clk        (clk),
    .rst        (rst),
    .fetch_inc  (if_valid & ~stall),
    .bubble_inc (~rst & ~if_valid),
    .fetch_cnt  (perf_fetch_cnt),
    .bubble_cnt (perf_bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: instruction memory model, reference model
// of what decode must see, and directed vectors with literal expectations.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned IMEM_WORDS = 513;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic        imem_nop;
  logic [31:0] imem_instr;
  logic        imem_nop_ret;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        if_fault;
  logic [31:0] if_fault_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [IMEM_WORDS];

  if_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_nop       (imem_nop),
    .imem_instr     (imem_instr),
    .imem_nop_ret   (imem_nop_ret),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_valid       (if_valid),
    .if_fault       (if_fault),
    .if_fault_pc    (if_fault_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < 32'(IMEM_WORDS));
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if ((a >> 2) < 32'(IMEM_WORDS)) return mem[int'(a >> 2)];
    return 32'hDEAD_DEAD;
  endfunction

  // Instruction memory: registered read, holds data while not enabled.
  always @(posedge clk) begin
    if (rst) begin
      imem_instr   <= '0;
      imem_nop_ret <= 1'b0;
    end else begin
      imem_nop_ret <= imem_nop;
      if (imem_en) imem_instr <= imem_nop ? NOP : word_at(imem_addr);
    end
  end

  // Reference model: what decode is currently shown, and where fetching resumes.
  bit          m_armed = 1'b0;
  bit          m_boot;
  bit          m_halt;
  bit          m_shown;
  logic [31:0] m_shown_pc;
  logic [31:0] m_next_pc;
  logic [31:0] m_fault_pc;
  logic [31:0] m_fetch_cnt;
  logic [31:0] m_bubble_cnt;

  function automatic bit exp_en();
    if (rst)            return 1'b0;
    if (m_boot)         return 1'b1;
    if (m_halt)         return 1'b0;
    if (redirect_valid) return legal(redirect_pc);
    if (stall)          return 1'b0;
    return legal(m_next_pc);
  endfunction

  function automatic bit exp_nop();
    return !rst && !m_boot && !m_halt && redirect_valid && legal(redirect_pc);
  endfunction

  function automatic bit exp_valid();
    return !rst && !m_boot && !m_halt && !redirect_valid && m_shown;
  endfunction

  function automatic bit exp_fault();
    return !rst && m_halt && !(redirect_valid && legal(redirect_pc));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_armed      <= 1'b1;
      m_boot       <= 1'b1;
      m_halt       <= 1'b0;
      m_shown      <= 1'b0;
      m_shown_pc   <= RESET_PC;
      m_next_pc    <= RESET_PC;
      m_fault_pc   <= '0;
      m_fetch_cnt  <= '0;
      m_bubble_cnt <= '0;
    end else if (m_armed) begin
      if (exp_valid() && !stall) m_fetch_cnt <= m_fetch_cnt + 32'd1;
      if (!exp_valid()) m_bubble_cnt <= m_bubble_cnt + 32'd1;
      if (m_boot) begin
        m_boot     <= 1'b0;
        m_shown    <= 1'b1;
        m_shown_pc <= RESET_PC;
        m_next_pc  <= RESET_PC + 32'd4;
      end else if (m_halt) begin
        if (redirect_valid && legal(redirect_pc)) begin
          m_halt    <= 1'b0;
          m_next_pc <= redirect_pc;
        end
      end else if (redirect_valid) begin
        m_shown <= 1'b0;
        if (legal(redirect_pc)) m_next_pc <= redirect_pc;
        else begin
          m_halt     <= 1'b1;
          m_fault_pc <= redirect_pc;
        end
      end else if (!stall) begin
        if (legal(m_next_pc)) begin
          m_shown    <= 1'b1;
          m_shown_pc <= m_next_pc;
          m_next_pc  <= m_next_pc + 32'd4;
        end else begin
          m_shown    <= 1'b0;
          m_halt     <= 1'b1;
          m_fault_pc <= m_next_pc;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_armed) begin
      check_bit("imem_en", imem_en, exp_en());
      check_bit("imem_nop", imem_nop, exp_nop());
      if (exp_en()) check("imem_addr", imem_addr, m_next_pc);
      check_bit("if_valid", if_valid, exp_valid());
      if (exp_valid()) begin
        check("if_pc", if_pc, m_shown_pc);
        check("if_instr", if_instr, word_at(m_shown_pc));
      end
      check_bit("if_fault", if_fault, exp_fault());
      check("if_fault_pc", if_fault_pc, rst ? 32'h0 : m_fault_pc);
      if (rst) begin
        check("rst_if_pc", if_pc, RESET_PC);
        check("rst_imem_addr", imem_addr, RESET_PC);
      end
`ifdef IF_PERF_CNT_EN
      check("perf_fetch_cnt", perf_fetch_cnt, m_fetch_cnt);
      check("perf_bubble_cnt", perf_bubble_cnt, m_bubble_cnt);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic rv, input logic [31:0] rp);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rp;
  endtask

  initial begin
    mem[0] = 32'hAAAA_0000;
    mem[1] = 32'hBBBB_0004;
    mem[2] = 32'hCCCC_0008;
    mem[3] = 32'hDDDD_000C;
    for (int i = 4; i < int'(IMEM_WORDS); i++) mem[i] = 32'hC0DE_0000 | 32'(i);

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    tick(); tick();
    #3;
    check_bit("reset en", imem_en, 1'b0);
    check_bit("reset valid", if_valid, 1'b0);
    check("reset if_pc", if_pc, 32'h0);
    check_bit("reset fault", if_fault, 1'b0);

    tick(); rst = 1'b0;                           // cycle 1: BOOT
    #3; check_bit("boot en", imem_en, 1'b1); check("boot addr", imem_addr, 32'h0);
    check_bit("boot valid", if_valid, 1'b0);
    tick(); #3;                                   // cycle 2
    check_bit("c2 valid", if_valid, 1'b1); check("c2 pc", if_pc, 32'h0);
    check("c2 instr", if_instr, 32'hAAAA_0000);
    tick(); #3;
    check("c3 pc", if_pc, 32'h4); check("c3 instr", if_instr, 32'hBBBB_0004);

    tick(); drive(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin             // three stalled cycles at pc 8
      #3;
      check("stall pc", if_pc, 32'h8); check("stall instr", if_instr, 32'hCCCC_0008);
      check_bit("stall en", imem_en, 1'b0);
      if (k < 2) tick();
    end
    tick(); drive(1'b0, 1'b0, 32'h0);             // release
    #3; check("release addr", imem_addr, 32'hC);
    tick(); drive(1'b0, 1'b1, 32'h40);            // redirect while fetching 0x10
    #3; check("c8 pc", if_pc, 32'hC); check("c8 instr", if_instr, 32'hDDDD_000C);
    check("redir addr", imem_addr, 32'h10); check_bit("redir nop", imem_nop, 1'b1);
    check_bit("redir valid", if_valid, 1'b0);
    tick(); drive(1'b0, 1'b0, 32'h0);
    #3; check_bit("squash valid", if_valid, 1'b0); check("squash instr", if_instr, NOP);
    check("target addr", imem_addr, 32'h40);
    tick(); #3;
    check_bit("target valid", if_valid, 1'b1); check("target pc", if_pc, 32'h40);
    check("target instr", if_instr, 32'hC0DE_0010);

    tick(); drive(1'b1, 1'b1, 32'h100);           // stall and redirect together
    #3; check_bit("sr nop", imem_nop, 1'b1);
    tick(); drive(1'b0, 1'b0, 32'h0);
    #3; check_bit("sr bubble", if_valid, 1'b0);
    tick(); #3;
    check("sr pc", if_pc, 32'h100); check("sr instr", if_instr, 32'hC0DE_0040);

    tick(); drive(1'b0, 1'b1, 32'h42);            // misaligned target
    #3; check_bit("mis en", imem_en, 1'b0);
    tick(); drive(1'b0, 1'b0, 32'h0);
    #3; check_bit("halt fault", if_fault, 1'b1); check("halt fault_pc", if_fault_pc, 32'h42);
    check_bit("halt en", imem_en, 1'b0);
    tick(); drive(1'b1, 1'b0, 32'h0);
    #3; check_bit("halt stall fault", if_fault, 1'b1);
    tick(); drive(1'b0, 1'b1, 32'h80);            // legal exit from HALT
    #3; check_bit("exit fault", if_fault, 1'b0);
    tick(); drive(1'b0, 1'b0, 32'h0);
    #3; check_bit("exit bubble", if_valid, 1'b0); check("exit addr", imem_addr, 32'h80);
    tick(); #3;
    check("exit pc", if_pc, 32'h80); check("exit instr", if_instr, 32'hC0DE_0020);

    tick(); drive(1'b0, 1'b1, 32'h800);           // last legal word, then walk off the end
    tick(); drive(1'b0, 1'b0, 32'h0);
    tick(); #3;
    check("last pc", if_pc, 32'h800); check("last instr", if_instr, 32'hC0DE_0200);
    check_bit("oob en", imem_en, 1'b0);
    tick(); #3;
    check_bit("oob fault", if_fault, 1'b1); check("oob fault_pc", if_fault_pc, 32'h804);

    tick(); rst = 1'b1;                           // reset out of HALT
    #3; check_bit("rst halt fault", if_fault, 1'b0);
    tick(); rst = 1'b0; drive(1'b1, 1'b0, 32'h0); // stall during BOOT is ignored
    #3; check_bit("boot stall en", imem_en, 1'b1);
    tick(); drive(1'b0, 1'b0, 32'h0);
    #3; check("reboot pc", if_pc, 32'h0); check("reboot instr", if_instr, 32'hAAAA_0000);

    for (int k = 0; k < 10; k++) tick();
    tick(); drive(1'b0, 1'b1, 32'h20);
    tick(); drive(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) tick();

    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
